nios2_jtag_dbg_cmd_decoder: RTL
===============================

Name: nios2_jtag_dbg_cmd_decoder

Overview:
- Parametrised system-clock-side command decoder for the Nios II JTAG debug path.
- Synchronises the virtual-JTAG update strobes (vs_uir, vs_udr) into clk and captures the instruction and shift register.
- Decodes the command into per-channel take_action / take_no_action strobes, generalised to 2**IR_W channels.
- Adds an optional acknowledge handshake and a saturating overrun counter for commands dropped while busy.

Parameters:
IR_W, 2, virtual IR width; channel count NUM_CH = 2**IR_W (derived, not overridable)
SR_W, 38, shift-register / jdo width
ACT_BIT, 37, sr bit selecting action (1) vs no-action (0); must be < SR_W
SYNC_STAGES, 2, synchroniser depth for vs_uir and vs_udr; legal range 2..4
OVR_W, 4, overrun counter width

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
ir_in  input  IR_W  virtual IR from TCK domain; stable by protocol when vs_uir is asserted
sr  input  SR_W  shift register from TCK domain; stable by protocol from vs_udr until the next capture-DR
vs_uir  input  1  update-IR strobe, asynchronous to clk
vs_udr  input  1  update-DR strobe, asynchronous to clk
cmd_ack  input  1  consumer acknowledge; used only with the optional feature
ovr_clr  input  1  synchronous clear of ovr_cnt
jdo  output  SR_W  captured command data
ir_q  output  IR_W  captured instruction
take_action  output  NUM_CH  one-hot action strobe
take_no_action  output  NUM_CH  one-hot no-action strobe
busy  output  1  FSM not IDLE
ovr_cnt  output  OVR_W  count of dropped udr events

Behaviour:
- Single clock domain clk; reset_n asynchronous active-low. Reset clears to 0: all synchroniser and edge registers, jdo, ir_q, take_action, take_no_action, busy, ovr_cnt, and the FSM (to IDLE).
- Each strobe passes through a SYNC_STAGES flop chain, then a delay flop. The rising edge is the last stage high and the delay flop low.
- uir edge: ir_q <= ir_in at the next clk edge. Accepted in any FSM state; never counts as an overrun.
- udr edge in IDLE:
  - At the next clk edge: jdo <= sr; channel c = current ir_q; FSM -> ISSUE.
  - If sr[ACT_BIT] = 1, take_action[c] <= 1; otherwise take_no_action[c] <= 1. All other strobe bits stay 0.
- Latency: strobe asserts at clk edge SYNC_STAGES+1, counting the first edge that samples vs_udr high as edge 1.
- If uir and udr edges are detected in the same cycle, the newly captured ir_in is the decoded channel (uir has priority).
- Pulse mode (feature off):
  - ISSUE lasts exactly 1 cycle, then strobes clear and FSM -> IDLE.
  - Consecutive udr edges are at least 2 cycles apart, so pulse mode never overruns.
- udr edge while FSM not IDLE: event dropped; jdo, ir_q and strobes unchanged; ovr_cnt increments, saturating at 2**OVR_W-1.
- ovr_clr in the same cycle as an overrun: the clear wins, ovr_cnt = 0.
- busy = (state != IDLE), registered together with the state.
- At most one bit set across take_action | take_no_action at any time.
- Reset asserted mid-ISSUE or mid-WAIT_ACK: all strobes drop immediately (asynchronously); a pending command is discarded.

Optional Feature:
- Macro: NIOS2_JTAG_DBG_CMD_ACK_EN.
- Defined:
  - ISSUE goes to WAIT_ACK; the selected strobe is held high until cmd_ack is sampled 1.
  - Strobe clears and FSM -> IDLE at that same clk edge.
  - cmd_ack sampled high in the ISSUE cycle also completes the command (1-cycle strobe).
  - udr edges during ISSUE or WAIT_ACK count as overruns.
- Undefined: cmd_ack is ignored and the WAIT_ACK state is not built; pulse mode only.

Test Plan:
1. Hold reset_n = 0 with all inputs toggling -> every output 0; release reset -> outputs remain 0 and busy = 0.
2. uir with ir_in = 1, then udr with sr = 38'h20_0000_1234 (SYNC_STAGES = 2) -> ir_q = 1, jdo = 38'h20_0000_1234, take_action = 4'b0010 for exactly 1 cycle at edge 3, take_no_action = 0.
3. ir_in = 3, sr[37] = 0, sr = 38'h0_DEAD_BEEF -> take_no_action = 4'b1000 for 1 cycle; take_action stays 0.
4. ACK_EN build: cmd_ack held 0 while 17 further udr edges arrive -> strobe stays high, ovr_cnt saturates at 15, jdo unchanged; then cmd_ack = 1 -> strobe clears, busy = 0; ovr_clr -> ovr_cnt = 0.
5. uir (ir_in = 2) and udr edges synchronised in the same cycle, prior ir_q = 0 -> strobe on channel 2, not channel 0.
6. ACK_EN build: assert reset_n low during WAIT_ACK -> strobe and busy drop to 0 without a clk edge; after release, the next udr decodes normally.

Source files
------------

// File: rtl/nios2_jtag_dbg_cmd_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : nios2_jtag_dbg_cmd_decoder                                    |
// | Purpose  : clk-side decoder of Nios II virtual-JTAG debug commands into  |
// |            per-channel action / no-action strobes. Optional acknowledge  |
// |            handshake is enabled by NIOS2_JTAG_DBG_CMD_ACK_EN.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module nios2_jtag_dbg_cmd_decoder #(
    parameter int IR_W        = 2,
    parameter int SR_W        = 38,
    parameter int ACT_BIT     = 37,
    parameter int SYNC_STAGES = 2,
    parameter int OVR_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [IR_W-1:0]       ir_in,
    input  logic [SR_W-1:0]       sr,
    input  logic                  vs_uir,
    input  logic                  vs_udr,
    input  logic                  cmd_ack,
    input  logic                  ovr_clr,
    output logic [SR_W-1:0]       jdo,
    output logic [IR_W-1:0]       ir_q,
    output logic [(2**IR_W)-1:0]  take_action,
    output logic [(2**IR_W)-1:0]  take_no_action,
    output logic                  busy,
    output logic [OVR_W-1:0]      ovr_cnt
);

    localparam int NUM_CH = 2**IR_W;
    localparam logic [OVR_W-1:0]  c_ovr_max = {OVR_W{1'b1}};
    localparam logic [OVR_W-1:0]  c_ovr_one = {{(OVR_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_CH-1:0] c_ch_one  = {{(NUM_CH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
`ifdef NIOS2_JTAG_DBG_CMD_ACK_EN
        ST_WAIT_ACK = 2'd2,
`endif
        ST_ISSUE    = 2'd1
    } state_t;

    logic [SYNC_STAGES-1:0] r_uir_sync;
    logic [SYNC_STAGES-1:0] r_udr_sync;
    logic                   r_uir_dly;
    logic                   r_udr_dly;
    logic                   w_uir_rise;
    logic                   w_udr_rise;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SR_W-1:0]        r_jdo;
    logic [IR_W-1:0]        r_ir_q;
    logic [NUM_CH-1:0]      r_take_action;
    logic [NUM_CH-1:0]      r_take_no_action;
    logic [NUM_CH-1:0]      w_act_nxt;
    logic [NUM_CH-1:0]      w_noact_nxt;
    logic                   r_busy;
    logic [OVR_W-1:0]       r_ovr_cnt;
    logic                   w_accept;
    logic                   w_ovr_hit;
    logic [IR_W-1:0]        w_ch;
    logic [NUM_CH-1:0]      w_ch_onehot;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_uir_sync <= '0;
            r_udr_sync <= '0;
            r_uir_dly  <= 1'b0;
            r_udr_dly  <= 1'b0;
        end else begin
            r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
            r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
            r_uir_dly  <= r_uir_sync[SYNC_STAGES-1];
            r_udr_dly  <= r_udr_sync[SYNC_STAGES-1];
        end
    end

    assign w_uir_rise = r_uir_sync[SYNC_STAGES-1] & ~r_uir_dly;
    assign w_udr_rise = r_udr_sync[SYNC_STAGES-1] & ~r_udr_dly;

    // A coincident update-IR wins: decode against the instruction being captured now.
    assign w_ch        = w_uir_rise ? ir_in : r_ir_q;
    assign w_ch_onehot = c_ch_one << w_ch;
    assign w_ovr_hit   = w_udr_rise && (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_act_nxt   = r_take_action;
        w_noact_nxt = r_take_no_action;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_udr_rise) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ISSUE;
                    if (sr[ACT_BIT]) begin
                        w_act_nxt = w_ch_onehot;
                    end else begin
                        w_noact_nxt = w_ch_onehot;
                    end
                end
            end
            ST_ISSUE: begin
`ifdef NIOS2_JTAG_DBG_CMD_ACK_EN
                if (cmd_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_act_nxt   = '0;
                    w_noact_nxt = '0;
                end else begin
                    w_state_nxt = ST_WAIT_ACK;
                end
`else
                w_state_nxt = ST_IDLE;
                w_act_nxt   = '0;
                w_noact_nxt = '0;
`endif
            end
`ifdef NIOS2_JTAG_DBG_CMD_ACK_EN
            ST_WAIT_ACK: begin
                if (cmd_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_act_nxt   = '0;
                    w_noact_nxt = '0;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_act_nxt   = '0;
                w_noact_nxt = '0;
            end
        endcase
    end

`ifndef NIOS2_JTAG_DBG_CMD_ACK_EN
    logic w_unused_cmd_ack;
    assign w_unused_cmd_ack = cmd_ack;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_IDLE;
            r_busy           <= 1'b0;
            r_jdo            <= '0;
            r_ir_q           <= '0;
            r_take_action    <= '0;
            r_take_no_action <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_busy           <= (w_state_nxt != ST_IDLE);
            r_take_action    <= w_act_nxt;
            r_take_no_action <= w_noact_nxt;
            if (w_uir_rise) begin
                r_ir_q <= ir_in;
            end
            if (w_accept) begin
                r_jdo <= sr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovr_cnt <= '0;
        end else if (ovr_clr) begin
            r_ovr_cnt <= '0;
        end else if (w_ovr_hit && (r_ovr_cnt != c_ovr_max)) begin
            r_ovr_cnt <= r_ovr_cnt + c_ovr_one;
        end
    end

    assign jdo            = r_jdo;
    assign ir_q           = r_ir_q;
    assign take_action    = r_take_action;
    assign take_no_action = r_take_no_action;
    assign busy           = r_busy;
    assign ovr_cnt        = r_ovr_cnt;

endmodule
`default_nettype wire
